ext_align_unit: RTL and testbench

- Pipelined successor to the combinational immediate extender, parametrised in data/immediate width.
- Adds load-data byte/halfword lane selection with sign/zero extension, and LUI-style upper placement.
- Adds misalignment detection with a saturating error counter and a valid/ready handshake on both sides via a 2-entry skid buffer.
- Sits between the decode/ID immediate path or the MEM-stage load data return and the downstream pipeline register.

---
 rtl/ext_align_if.sv | 26 ++
 rtl/ext_align_unit.sv | 142 ++++++++++++++
 tb/tb_ext_align_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_align_if.sv
// Handshake bundle for the extend/align unit: input request side
// and registered result side.
interface ext_align_if #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_off;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output in_valid, in_op, in_data, in_off, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_off, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/ext_align_unit.sv
// Pipelined immediate extender / load lane aligner with misalignment
// detection, saturating error counter and a 2-entry skid buffer.
module ext_align_unit #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 8,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    ext_align_if.slave       bus,
    input  logic             err_cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic [2:0] {
        OP_ZEXT  = 3'd0,
        OP_SEXT  = 3'd1,
        OP_UPPER = 3'd2,
        OP_LB    = 3'd3,
        OP_LBU   = 3'd4,
        OP_LH    = 3'd5,
        OP_LHU   = 3'd6,
        OP_WORD  = 3'd7
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    op_e               op;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] res;
    logic              mis;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_err_q, skid_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic accept;
    logic consume;

    assign op   = op_e'(bus.in_op);
    assign imm  = bus.in_data[IMM_W-1:0];
    // Selected byte/halfword lands in the low bits of lane
    assign lane = bus.in_data >> {bus.in_off, 3'b000};

    always_comb begin
        mis = 1'b0;
        res = '0;
        unique case (op)
            OP_ZEXT:  res = {{(DATA_W-IMM_W){1'b0}}, imm};
            OP_SEXT:  res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            OP_UPPER: res = {imm, {(DATA_W-IMM_W){1'b0}}};
            OP_LB:    res = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            OP_LBU:   res = {{(DATA_W-8){1'b0}}, lane[7:0]};
            OP_LH: begin
                mis = bus.in_off[0];
                res = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            end
            OP_LHU: begin
                mis = bus.in_off[0];
                res = {{(DATA_W-16){1'b0}}, lane[15:0]};
            end
            OP_WORD: begin
                mis = (bus.in_off != '0);
                res = bus.in_data;
            end
        endcase
        if (mis) begin
            res = '0;
        end
    end

    assign accept  = bus.in_valid && !skid_valid_q;
    assign consume = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;
        if (consume || !out_valid_q) begin
            // Skid entry is older than anything arriving now
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = res;
                out_err_d   = mis;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = res;
            skid_err_d   = mis;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = (accept && mis) ? CNT_W'(1) : '0;
        end else if (accept && mis && err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_ext_align_unit.sv
// Directed plus randomized check of ext_align_unit against a
// queue-based reference model of the result stream and error count.
module tb_ext_align_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_cnt_clr = 1'b0;
    logic [1:0] err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ext_align_if #(.DATA_W(32)) bus ();

    ext_align_unit #(
        .DATA_W(32),
        .IMM_W (16),
        .CNT_W (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .err_cnt_clr(err_cnt_clr),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: {err, data} from plain arithmetic on lane values
    function automatic logic [32:0] model(input logic [2:0] op,
                                          input logic [31:0] d,
                                          input logic [1:0] off);
        int unsigned o;
        longint v;
        o = int'(off);
        if (((op == 3'd5 || op == 3'd6) && (o % 2 == 1)) ||
            (op == 3'd7 && o != 0))
            return {1'b1, 32'h0};
        case (op)
            3'd0: v = longint'(d % 65536);
            3'd1: begin
                v = longint'(d % 65536);
                if (v >= 32768) v = v - 65536;
            end
            3'd2: v = longint'(d % 65536) * 65536;
            3'd3: begin
                v = longint'((d >> (8 * o)) % 256);
                if (v >= 128) v = v - 256;
            end
            3'd4: v = longint'((d >> (8 * o)) % 256);
            3'd5: begin
                v = longint'((d >> (8 * o)) % 65536);
                if (v >= 32768) v = v - 65536;
            end
            3'd6: v = longint'((d >> (8 * o)) % 65536);
            default: v = longint'(d);
        endcase
        return {1'b0, v[31:0]};
    endfunction

    logic [32:0] q[$];
    int          mcnt = 0;
    bit          held = 0;
    logic [32:0] held_v;

    always @(negedge clk) begin
        logic [32:0] e;
        bit inc;
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
            held = 0;
        end else begin
            chk("err_cnt", 64'(err_cnt), 64'(mcnt));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            if (held)
                chk("hold", {31'b0, bus.out_valid, bus.out_err, bus.out_data},
                    {31'b0, 1'b1, held_v});
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(e[31:0]));
                    chk("out_err", 64'(bus.out_err), 64'(e[32]));
                end
            end
            held = bus.out_valid && !bus.out_ready;
            held_v = {bus.out_err, bus.out_data};
            inc = 0;
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.in_op, bus.in_data, bus.in_off);
                q.push_back(e);
                inc = e[32];
            end
            if (err_cnt_clr) mcnt = inc ? 1 : 0;
            else if (inc && mcnt < 3) mcnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] d,
                         input logic [1:0] off);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_off   = off;
    endtask

    task automatic xact(input string tag, input logic [2:0] op,
                        input logic [31:0] d, input logic [1:0] off,
                        input logic [31:0] exp, input logic exp_err);
        drive(op, d, off);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(bus.out_valid), 64'(1));
        chk({tag, "_data"}, 64'(bus.out_data), 64'(exp));
        chk({tag, "_err"}, 64'(bus.out_err), 64'(exp_err));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_data   = '0;
        bus.in_off    = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_err", 64'(bus.out_err), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        step();
        rst_n = 1'b1;
        step();

        xact("zext", 3'd0, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0);
        xact("sext", 3'd1, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0);
        xact("upper", 3'd2, 32'h0000_8001, 2'd0, 32'h8001_0000, 1'b0);
        xact("lb0", 3'd3, 32'h80F1_7F82, 2'd0, 32'hFFFF_FF82, 1'b0);
        xact("lbu0", 3'd4, 32'h80F1_7F82, 2'd0, 32'h0000_0082, 1'b0);
        xact("lb1", 3'd3, 32'h80F1_7F82, 2'd1, 32'h0000_007F, 1'b0);
        xact("lh2", 3'd5, 32'h80F1_7F82, 2'd2, 32'hFFFF_80F1, 1'b0);
        xact("lhu2", 3'd6, 32'h80F1_7F82, 2'd2, 32'h0000_80F1, 1'b0);
        xact("lh1_mis", 3'd5, 32'h80F1_7F82, 2'd1, 32'h0, 1'b1);
        chk("cnt_1", 64'(err_cnt), 64'(1));
        xact("word2_mis", 3'd7, 32'h80F1_7F82, 2'd2, 32'h0, 1'b1);
        chk("cnt_2", 64'(err_cnt), 64'(2));
        xact("sext_off3", 3'd1, 32'h80F1_7F82, 2'd3, 32'h0000_7F82, 1'b0);
        chk("cnt_keep", 64'(err_cnt), 64'(2));

        for (int i = 0; i < 5; i++)
            xact("sat_mis", 3'd6, 32'h1234_5678, 2'd3, 32'h0, 1'b1);
        chk("cnt_sat", 64'(err_cnt), 64'(3));
        err_cnt_clr = 1'b1;
        step();
        err_cnt_clr = 1'b0;
        chk("cnt_clr", 64'(err_cnt), 64'(0));
        err_cnt_clr = 1'b1;
        xact("clr_mis", 3'd5, 32'h0, 2'd1, 32'h0, 1'b1);
        err_cnt_clr = 1'b0;
        chk("cnt_clr_evt", 64'(err_cnt), 64'(1));

        step();
        step();
        bus.out_ready = 1'b0;
        drive(3'd0, 32'h0000_1111, 2'd0);
        step();
        chk("bp_a_out", 64'(bus.out_data), 64'(32'h0000_1111));
        drive(3'd2, 32'h0000_2222, 2'd0);
        step();
        chk("bp_full", 64'(bus.in_ready), 64'(0));
        drive(3'd4, 32'h0000_0033, 2'd0);
        step();
        chk("bp_c_held", 64'(bus.in_ready), 64'(0));
        chk("bp_a_stable", 64'(bus.out_data), 64'(32'h0000_1111));
        bus.out_ready = 1'b1;
        step();
        chk("bp_b_out", 64'(bus.out_data), 64'(32'h2222_0000));
        step();
        bus.in_valid = 1'b0;
        chk("bp_c_out", 64'(bus.out_data), 64'(32'h0000_0033));
        step();
        chk("bp_drained", 64'(bus.out_valid), 64'(0));

        bus.out_ready = 1'b0;
        drive(3'd7, 32'hDEAD_BEEF, 2'd1);
        step();
        drive(3'd0, 32'h0000_4444, 2'd0);
        step();
        bus.in_valid = 1'b0;
        chk("pre_rst_full", 64'(bus.in_ready), 64'(0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_err_cnt", 64'(err_cnt), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        chk("arst_in_ready", 64'(bus.in_ready), 64'(1));
        step();
        xact("post_rst", 3'd1, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0);

        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_op     = 3'($urandom_range(0, 7));
            bus.in_data   = $urandom;
            bus.in_off    = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 9) < 6);
            err_cnt_clr   = ($urandom_range(0, 19) == 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        err_cnt_clr   = 1'b0;
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        #1;
        chk("final_drain", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
